cacheline_mem_arbiter: RTL and testbench

Shares the single burst main-memory port between the instruction cache and the data cache. Accepts one 256-bit cacheline read (icache) or read/write (dcache) at a time, arbitrates, and converts it to a 4-beat 64-bit burst. Returns the assembled line with a one-cycle response to the granted cache. Sits between the two caches and the top-level `mem_*` ports of `mp4`.

---
 rtl/cacheline_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_cacheline_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates icache/dcache cacheline requests onto one burst memory port,
// splitting each 256-bit line into BEAT_W-bit beats and reassembling reads.
module cacheline_mem_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((LINE_W / 8) - 1);

  typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  beat;
  logic              last_grant_d;
  logic              grant_d;
  logic              pick_d;
  logic              any_req;
  logic              last_beat;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] line_q;

  // On a tie the cache that did not win last time is granted.
  always_comb begin
    any_req = i_pmem_read | d_pmem_read | d_pmem_write;
    pick_d  = d_pmem_read | d_pmem_write;
    if (i_pmem_read && (d_pmem_read || d_pmem_write))
      pick_d = ~last_grant_d;
    last_beat = mem_resp && (beat == CNT_W'(BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          if (!pick_d)          state_next = I_READ;
          else if (d_pmem_write) state_next = D_WRITE;
          else                   state_next = D_READ;
        end
      end
      I_READ, D_READ, D_WRITE: if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat         <= '0;
      last_grant_d <= 1'b0;
      grant_d      <= 1'b0;
      addr_q       <= '0;
      wline_q      <= '0;
      line_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            addr_q       <= (pick_d ? d_pmem_address : i_pmem_address) & ALIGN_MASK;
            beat         <= '0;
            grant_d      <= pick_d;
            last_grant_d <= pick_d;
            if (pick_d && d_pmem_write) wline_q <= d_pmem_wdata;
          end
        end
        I_READ, D_READ: begin
          if (mem_resp) begin
            for (int unsigned k = 0; k < BEATS; k++)
              if (beat == CNT_W'(k)) line_q[k*BEAT_W +: BEAT_W] <= mem_rdata;
            beat <= beat + 1'b1;
          end
        end
        D_WRITE: if (mem_resp) beat <= beat + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    unique case (state)
      I_READ, D_READ: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
      end
      D_WRITE: begin
        mem_write   = 1'b1;
        mem_address = addr_q;
        for (int unsigned k = 0; k < BEATS; k++)
          if (beat == CNT_W'(k)) mem_wdata = wline_q[k*BEAT_W +: BEAT_W];
      end
      DONE: begin
        i_pmem_resp = ~grant_d;
        d_pmem_resp = grant_d;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = line_q;
  assign d_pmem_rdata = line_q;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Self-checking bench for cacheline_mem_arbiter: transaction-level model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_cacheline_mem_arbiter;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_pmem_read = 1'b0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 1'b0;
  logic          d_pmem_write = 1'b0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  always #5 clk = ~clk;

  cacheline_mem_arbiter #(.LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: phase 0 = waiting for a request, 1 = moving beats,
  // 2 = reply cycle. Beats counted as a plain integer.
  int            m_phase = 0;
  bit            m_dc, m_wr;
  bit            m_last_d = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wline = '0;
  logic [LW-1:0] m_rbuf = '0;
  int            m_beats = 0;

  bit mem_auto = 1'b0;
  bit agents   = 1'b0;
  int resp_pct = 60;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_update();
    bit want_d;
    logic [AW-1:0] a;
    if (rst) begin
      m_phase = 0; m_beats = 0; m_rbuf = '0; m_last_d = 1'b0; m_addr = '0;
    end else begin
      case (m_phase)
        0: if (i_pmem_read || d_pmem_read || d_pmem_write) begin
             want_d = d_pmem_read || d_pmem_write;
             if (i_pmem_read && want_d) want_d = !m_last_d;
             m_dc = want_d;
             m_last_d = want_d;
             m_wr = want_d && d_pmem_write;
             a = want_d ? d_pmem_address : i_pmem_address;
             m_addr = {a[AW-1:5], 5'b0};
             m_wline = d_pmem_wdata;
             m_beats = 0;
             m_phase = 1;
           end
        1: if (mem_resp) begin
             if (!m_wr) m_rbuf[m_beats*BW +: BW] = mem_rdata;
             m_beats++;
             if (m_beats == 4) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic check();
    logic [BW-1:0] exp_wd;
    exp_wd = '0;
    if (m_phase == 1 && m_wr) exp_wd = m_wline[m_beats*BW +: BW];
    chk("mem_read",    LW'(mem_read),    LW'(m_phase == 1 && !m_wr));
    chk("mem_write",   LW'(mem_write),   LW'(m_phase == 1 && m_wr));
    chk("mem_address", LW'(mem_address), LW'(m_phase == 1 ? m_addr : '0));
    chk("mem_wdata",   LW'(mem_wdata),   LW'(exp_wd));
    chk("i_pmem_resp", LW'(i_pmem_resp), LW'(m_phase == 2 && !m_dc));
    chk("d_pmem_resp", LW'(d_pmem_resp), LW'(m_phase == 2 && m_dc));
    if (m_phase == 2 && !m_dc) chk("i_pmem_rdata", i_pmem_rdata, m_rbuf);
    if (m_phase == 2 && m_dc && !m_wr) chk("d_pmem_rdata", d_pmem_rdata, m_rbuf);
  endtask

  task automatic auto_drive();
    int r;
    if (mem_auto) begin
      mem_resp  = ($urandom_range(0, 99) < resp_pct);
      mem_rdata = {$urandom(), $urandom()};
    end
    if (agents) begin
      if (i_pmem_resp) i_pmem_read = 1'b0;
      if (d_pmem_resp) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      if (!i_pmem_read && $urandom_range(0, 3) == 0) begin
        i_pmem_read = 1'b1;
        i_pmem_address = $urandom();
      end
      if (!d_pmem_read && !d_pmem_write && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(1, 3);
        d_pmem_read  = r[0];
        d_pmem_write = r[1];
        d_pmem_address = $urandom();
      end
      // Request payload may wander; only the value at grant time matters.
      if ($urandom_range(0, 7) == 0) begin
        for (int w = 0; w < LW / 32; w++) d_pmem_wdata[w*32 +: 32] = $urandom();
        d_pmem_address = $urandom();
        i_pmem_address = $urandom();
      end
      rst = ($urandom_range(0, 599) == 0);
    end
  endtask

  task automatic step();
    model_update();
    @(negedge clk);
    check();
    auto_drive();
  endtask

  // Memory responder: waits one cycle after the burst starts, then returns
  // one beat every gap+1 cycles until the requester sees its resp.
  task automatic run_burst(input int gap, input logic [LW-1:0] rline, output int lat,
                           output logic [LW-1:0] wcap, output logic [AW-1:0] addr_seen,
                           output bit saw_rd, output bit got_d);
    bit started, done;
    int nb, gapc;
    lat = 0; wcap = '0; addr_seen = '0; saw_rd = 1'b0; got_d = 1'b0;
    started = 1'b0; done = 1'b0; nb = 0; gapc = 0;
    mem_resp = 1'b0;
    while (!done && lat < 200) begin
      step();
      lat++;
      saw_rd |= mem_read;
      mem_resp = 1'b0;
      if (i_pmem_resp || d_pmem_resp) begin
        done = 1'b1;
        got_d = d_pmem_resp;
      end else if (mem_read || mem_write) begin
        if (!started) begin
          started = 1'b1;
          addr_seen = mem_address;
        end else if (gapc > 0) begin
          gapc--;
        end else if (nb < 4) begin
          mem_resp  = 1'b1;
          mem_rdata = rline[nb*BW +: BW];
          if (mem_write) wcap[nb*BW +: BW] = mem_wdata;
          nb++;
          gapc = gap;
        end
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL burst_timeout: got no resp within %0d cycles, expected one", lat);
    end
  endtask

  initial begin
    int lat;
    logic [LW-1:0] wcap, line;
    logic [AW-1:0] aseen;
    bit saw_rd, got_d;
    bit exp_order [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    step(); step();
    rst = 1'b0;
    chk("rst_mem_read", LW'(mem_read), '0);
    chk("rst_mem_address", LW'(mem_address), '0);
    chk("rst_i_rdata", i_pmem_rdata, '0);
    chk("rst_d_rdata", d_pmem_rdata, '0);

    // icache read
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0064;
    line = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    run_burst(0, line, lat, wcap, aseen, saw_rd, got_d);
    i_pmem_read = 1'b0;
    chk("t1_addr", LW'(aseen), LW'(32'h0000_0060));
    chk("t1_latency", LW'(lat), LW'(6));
    chk("t1_rdata", i_pmem_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    chk("t1_who", LW'(got_d), '0);
    step(); step();

    // dcache write
    d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0020;
    d_pmem_wdata = 256'hAAAA000000000003_AAAA000000000002_AAAA000000000001_AAAA000000000000;
    run_burst(0, '0, lat, wcap, aseen, saw_rd, got_d);
    d_pmem_write = 1'b0;
    chk("t2_addr", LW'(aseen), LW'(32'h8000_0020));
    chk("t2_wbeats", wcap,
        256'hAAAA000000000003_AAAA000000000002_AAAA000000000001_AAAA000000000000);
    chk("t2_latency", LW'(lat), LW'(6));
    chk("t2_who", LW'(got_d), LW'(1));
    chk("t2_no_read", LW'(saw_rd), '0);
    step(); step();

    // contention from reset: D, I, D, I
    rst = 1'b1; step(); rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      line = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      run_burst(0, line, lat, wcap, aseen, saw_rd, got_d);
      chk($sformatf("t3_grant%0d", k), LW'(got_d), LW'(exp_order[k]));
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    step(); step();

    // gapped write beats
    d_pmem_write = 1'b1; d_pmem_address = 32'h1234_5678;
    d_pmem_wdata = 256'h0D0D0D0D0D0D0D0D_0C0C0C0C0C0C0C0C_0B0B0B0B0B0B0B0B_0A0A0A0A0A0A0A0A;
    run_burst(2, '0, lat, wcap, aseen, saw_rd, got_d);
    d_pmem_write = 1'b0;
    chk("t4_addr", LW'(aseen), LW'(32'h1234_5660));
    chk("t4_latency", LW'(lat), LW'(12));
    chk("t4_wbeats", wcap,
        256'h0D0D0D0D0D0D0D0D_0C0C0C0C0C0C0C0C_0B0B0B0B0B0B0B0B_0A0A0A0A0A0A0A0A);
    step(); step();

    // reset mid-burst
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0040;
    step();
    mem_resp = 1'b1; mem_rdata = 64'h5555555555555555;
    step();
    mem_rdata = 64'h6666666666666666;
    step();
    rst = 1'b1; mem_resp = 1'b0; i_pmem_read = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_mem_read", LW'(mem_read), '0);
    chk("t5_no_resp", LW'(i_pmem_resp), '0);
    chk("t5_rdata", i_pmem_rdata, '0);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    run_burst(0, 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_0F1E2D3C4B5A6978,
              lat, wcap, aseen, saw_rd, got_d);
    i_pmem_read = 1'b0;
    chk("t5_latency", LW'(lat), LW'(6));
    chk("t5_rdata_after", i_pmem_rdata,
        256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_0F1E2D3C4B5A6978);
    step(); step();

    // read and write together
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0300;
    d_pmem_wdata = 256'h9999999999999999_8888888888888888_7777777777777777_6666666666666666;
    run_burst(0, '0, lat, wcap, aseen, saw_rd, got_d);
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    chk("t6_no_read", LW'(saw_rd), '0);
    chk("t6_wbeats", wcap,
        256'h9999999999999999_8888888888888888_7777777777777777_6666666666666666);
    step(); step();

    // random traffic against the model
    mem_auto = 1'b1; agents = 1'b1;
    repeat (3000) step();
    mem_auto = 1'b0; agents = 1'b0;
    rst = 1'b0; mem_resp = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
